// File: rtl/input_interface.sv
// Byte-serial front end of the AES engine: assembles 16 bytes, MSB first, into a
// plaintext block (valid/ready handoff) or a key (one-cycle strobe).
module input_interface #(
    parameter int unsigned IDLE_TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst_,
    input  logic [7:0]   data_in,
    input  logic         data_in_valid,
    input  logic         key_sel,
    input  logic         engine_ready,
    output logic         in_ready,
    output logic [127:0] plaintext,
    output logic         block_valid,
    output logic [127:0] key,
    output logic         key_valid,
    output logic         overflow_err,
    output logic         timeout_err
);

    typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

    localparam logic [7:0] IDLE_LIMIT = 8'(IDLE_TIMEOUT);

    state_t       state_q, state_d;
    logic [127:0] shift_q, shift_d;
    logic [127:0] plaintext_q, plaintext_d;
    logic [127:0] key_q, key_d;
    logic [4:0]   count_q, count_d;
    logic [7:0]   idle_q, idle_d;
    logic         dest_q, dest_d;
    logic         block_valid_q, block_valid_d;
    logic         key_valid_q, key_valid_d;
    logic         overflow_q, overflow_d;
    logic         timeout_q, timeout_d;
    logic         accept;
    logic [127:0] shifted;

    assign in_ready = (state_q != HOLD);
    assign accept   = data_in_valid & in_ready;
    assign shifted  = {shift_q[119:0], data_in};

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q       <= IDLE;
            shift_q       <= '0;
            plaintext_q   <= '0;
            key_q         <= '0;
            count_q       <= '0;
            idle_q        <= '0;
            dest_q        <= 1'b0;
            block_valid_q <= 1'b0;
            key_valid_q   <= 1'b0;
            overflow_q    <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            shift_q       <= shift_d;
            plaintext_q   <= plaintext_d;
            key_q         <= key_d;
            count_q       <= count_d;
            idle_q        <= idle_d;
            dest_q        <= dest_d;
            block_valid_q <= block_valid_d;
            key_valid_q   <= key_valid_d;
            overflow_q    <= overflow_d;
            timeout_q     <= timeout_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        plaintext_d   = plaintext_q;
        key_d         = key_q;
        count_d       = count_q;
        idle_d        = idle_q;
        dest_d        = dest_q;
        block_valid_d = block_valid_q;
        key_valid_d   = 1'b0;
        timeout_d     = 1'b0;
        overflow_d    = overflow_q | (data_in_valid & ~in_ready);

        case (state_q)
            IDLE: begin
                if (accept) begin
                    dest_d  = key_sel;
                    shift_d = shifted;
                    count_d = 5'd1;
                    idle_d  = '0;
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (accept) begin
                    idle_d = '0;
                    // 16th byte: publish the combined value on this same edge
                    if (count_q == 5'd15) begin
                        count_d = '0;
                        shift_d = '0;
                        if (dest_q) begin
                            key_d       = shifted;
                            key_valid_d = 1'b1;
                            state_d     = IDLE;
                        end else begin
                            plaintext_d   = shifted;
                            block_valid_d = 1'b1;
                            state_d       = HOLD;
                        end
                    end else begin
                        shift_d = shifted;
                        count_d = count_q + 5'd1;
                    end
                end else if (idle_q >= IDLE_LIMIT - 8'd1) begin
                    timeout_d = 1'b1;
                    count_d   = '0;
                    shift_d   = '0;
                    idle_d    = '0;
                    state_d   = IDLE;
                end else if (idle_q != '1) begin
                    idle_d = idle_q + 8'd1;
                end
            end
            HOLD: begin
                if (engine_ready) begin
                    block_valid_d = 1'b0;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign plaintext    = plaintext_q;
    assign block_valid  = block_valid_q;
    assign key          = key_q;
    assign key_valid    = key_valid_q;
    assign overflow_err = overflow_q;
    assign timeout_err  = timeout_q;

endmodule

// File: tb/tb_input_interface.sv
// Self-checking bench for input_interface: directed table, corner sequences and
// random traffic compared against a queue-based behavioural model.
module tb_input_interface;

    localparam int TO = 4;

    logic         clk = 1'b0;
    logic         rst_ = 1'b0;
    logic [7:0]   data_in = '0;
    logic         data_in_valid = 1'b0;
    logic         key_sel = 1'b0;
    logic         engine_ready = 1'b0;
    logic         in_ready;
    logic [127:0] plaintext;
    logic         block_valid;
    logic [127:0] key;
    logic         key_valid;
    logic         overflow_err;
    logic         timeout_err;

    int errors = 0;
    int checks = 0;

    input_interface #(.IDLE_TIMEOUT(TO)) dut (
        .clk(clk), .rst_(rst_), .data_in(data_in), .data_in_valid(data_in_valid),
        .key_sel(key_sel), .engine_ready(engine_ready), .in_ready(in_ready),
        .plaintext(plaintext), .block_valid(block_valid), .key(key),
        .key_valid(key_valid), .overflow_err(overflow_err), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Reference model: bytes of the block in progress kept in a queue
    logic [7:0]   mq[$];
    bit           m_dest, m_hold, m_bv, m_kv, m_ov, m_to;
    int           m_idle;
    logic [127:0] m_pt, m_key;

    task automatic model_reset();
        mq.delete();
        m_dest = 0; m_hold = 0; m_bv = 0; m_kv = 0; m_ov = 0; m_to = 0;
        m_idle = 0; m_pt = '0; m_key = '0;
    endtask

    function automatic logic [127:0] pack_queue();
        logic [127:0] r = '0;
        foreach (mq[i]) r = {r[119:0], mq[i]};
        return r;
    endfunction

    task automatic model_step(input bit dv, input logic [7:0] d, input bit ks, input bit er);
        m_kv = 0;
        m_to = 0;
        if (m_hold) begin
            if (dv) m_ov = 1;
            if (er) begin m_hold = 0; m_bv = 0; end
        end else if (dv) begin
            if (mq.size() == 0) m_dest = ks;
            mq.push_back(d);
            m_idle = 0;
            if (mq.size() == 16) begin
                if (m_dest) begin m_key = pack_queue(); m_kv = 1; end
                else begin m_pt = pack_queue(); m_bv = 1; m_hold = 1; end
                mq.delete();
            end
        end else if (mq.size() > 0) begin
            m_idle++;
            if (m_idle == TO) begin m_to = 1; m_idle = 0; mq.delete(); end
        end
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        chk("in_ready", 128'(in_ready), 128'(!m_hold));
        chk("plaintext", plaintext, m_pt);
        chk("block_valid", 128'(block_valid), 128'(m_bv));
        chk("key", key, m_key);
        chk("key_valid", 128'(key_valid), 128'(m_kv));
        chk("overflow_err", 128'(overflow_err), 128'(m_ov));
        chk("timeout_err", 128'(timeout_err), 128'(m_to));
    endtask

    task automatic cycle(input bit dv, input logic [7:0] d, input bit ks, input bit er);
        data_in_valid = dv; data_in = d; key_sel = ks; engine_ready = er;
        @(posedge clk);
        model_step(dv, d, ks, er);
        #1;
        compare_model();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_ = 0;
        data_in_valid = 1; data_in = 8'h55; key_sel = 0;
        model_reset();
        @(posedge clk); #1;
        compare_model();
        @(negedge clk);
        rst_ = 1;
        data_in_valid = 0;
    endtask

    typedef struct {
        bit         dv;
        logic [7:0] d;
        bit         er;
        bit         exp_bv;
        bit         exp_inr;
    } vec_t;

    vec_t tbl[21];
    localparam logic [127:0] PT_SEQ = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [127:0] KEYV   = 128'h2B7E151628AED2A6ABF7158809CF4F3C;
    logic [127:0] pt_saved;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 16; i++) tbl[i] = '{1, 8'(i), 0, (i == 15), (i != 15)};
        for (int i = 16; i < 19; i++) tbl[i] = '{0, 8'h00, 0, 1, 0};
        tbl[19] = '{0, 8'h00, 1, 0, 1};
        tbl[20] = '{0, 8'h00, 0, 0, 1};

        // Reset state
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_model();
        @(negedge clk);
        rst_ = 1;

        // Plaintext load via table
        for (int i = 0; i < 21; i++) begin
            cycle(tbl[i].dv, tbl[i].d, 0, tbl[i].er);
            chk("tbl_block_valid", 128'(block_valid), 128'(tbl[i].exp_bv));
            chk("tbl_in_ready", 128'(in_ready), 128'(tbl[i].exp_inr));
            if (i == 15) chk("tbl_plaintext", plaintext, PT_SEQ);
        end

        // Key load with key_sel toggling after the first byte
        for (int i = 0; i < 16; i++)
            cycle(1, KEYV[127 - 8*i -: 8], (i == 0) ? 1'b1 : bit'(i % 2 == 0), 0);
        chk("key_value", key, KEYV);
        chk("key_strobe", 128'(key_valid), 128'(1));
        chk("key_pt_unchanged", plaintext, PT_SEQ);
        cycle(0, 8'h00, 0, 0);
        chk("key_strobe_single", 128'(key_valid), 128'(0));
        chk("key_idle_ready", 128'(in_ready), 128'(1));

        // Overflow in HOLD, including the handshake edge
        for (int i = 0; i < 16; i++) cycle(1, 8'(8'hF0 - i), 0, 0);
        pt_saved = plaintext;
        cycle(1, 8'hAA, 0, 0);
        chk("ovf_set", 128'(overflow_err), 128'(1));
        chk("ovf_pt_stable", plaintext, pt_saved);
        cycle(1, 8'hBB, 0, 1);
        chk("ovf_handshake_drop", 128'(block_valid), 128'(0));
        repeat (3) cycle(0, 8'h00, 0, 0);
        chk("ovf_sticky", 128'(overflow_err), 128'(1));
        chk("ovf_pt_after", plaintext, pt_saved);
        do_reset();
        chk("ovf_cleared", 128'(overflow_err), 128'(0));

        // Timeout after 5 bytes, then a clean block
        for (int i = 0; i < 5; i++) cycle(1, 8'hC0 + 8'(i), 0, 0);
        for (int k = 1; k <= 5; k++) begin
            cycle(0, 8'h00, 0, 0);
            chk("timeout_pulse", 128'(timeout_err), 128'(k == TO));
        end
        for (int i = 0; i < 16; i++) cycle(1, 8'h10 + 8'(i), 0, 0);
        chk("after_timeout_block", plaintext, 128'h101112131415161718191A1B1C1D1E1F);
        cycle(0, 8'h00, 0, 1);

        // Asynchronous reset mid-block
        for (int i = 0; i < 9; i++) cycle(1, 8'h77, 0, 0);
        #3 rst_ = 0;
        model_reset();
        #1;
        chk("arst_plaintext", plaintext, '0);
        chk("arst_key", key, '0);
        chk("arst_flags", 128'({block_valid, key_valid, overflow_err, timeout_err}), '0);
        chk("arst_in_ready", 128'(in_ready), 128'(1));
        data_in_valid = 1; data_in = 8'h99;
        @(posedge clk); #1;
        compare_model();
        @(negedge clk) rst_ = 1;
        for (int i = 0; i < 16; i++) cycle(1, 8'h20 + 8'(i), 0, 0);
        chk("arst_new_block", plaintext, 128'h202122232425262728292A2B2C2D2E2F);
        cycle(0, 8'h00, 0, 1);

        // Gapped stream; engine_ready on the 16th-byte edge must not release HOLD
        for (int i = 0; i < 16; i++) begin
            cycle(1, 8'h30 + 8'(i), 0, (i == 15));
            if (i != 15) repeat (1 + (i % 3)) begin
                cycle(0, 8'h00, 0, 0);
                chk("gap_no_timeout", 128'(timeout_err), 128'(0));
            end
        end
        chk("gap_block", plaintext, 128'h303132333435363738393A3B3C3D3E3F);
        chk("gap_er_same_edge", 128'(block_valid), 128'(1));
        cycle(0, 8'h00, 0, 1);
        chk("gap_released", 128'(block_valid), 128'(0));

        // Random traffic against the model
        for (int n = 0; n < 1500; n++)
            cycle(($urandom_range(0, 9) < 7), 8'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/input_interface.md
Name: input_interface

Overview:
- Byte-serial receiver on the front end of the AES engine, mirroring the ciphertext output serializer.
- Collects 16 bytes, MSB first, from an 8-bit port into a 128-bit plaintext block or a 128-bit key.
- Presents a completed plaintext block to the round transformer through a valid/ready handshake.
- Publishes a loaded key with a one-cycle strobe.

Parameters:
- IDLE_TIMEOUT, 255: number of consecutive cycles without data_in_valid in COLLECT before a partial block is discarded. Range 1..255; the idle counter is 8 bits.

Ports:
- clk  in  1  system clock, rising edge.
- rst_  in  1  reset, asynchronous, active-low.
- data_in  in  8  input byte.
- data_in_valid  in  1  data_in is valid this cycle.
- key_sel  in  1  destination of the block: 0 = plaintext, 1 = key. Sampled only with the first byte of a block.
- engine_ready  in  1  round transformer can accept a plaintext block.
- in_ready  out  1  byte acceptance possible this cycle.
- plaintext  out  128  assembled plaintext block.
- block_valid  out  1  plaintext is valid and waiting for engine_ready.
- key  out  128  assembled key.
- key_valid  out  1  one-cycle pulse when a new key is written to key.
- overflow_err  out  1  sticky flag: a byte arrived while in_ready = 0.
- timeout_err  out  1  one-cycle pulse when a partial block is discarded.

Behaviour:
- Reset (rst_ low, asynchronous):
  - state = IDLE; shift register, byte count, idle counter and dest cleared.
  - plaintext = 0, key = 0; block_valid, key_valid, overflow_err, timeout_err all 0.
  - Bytes presented while rst_ is low are ignored.
  - Reset mid-block or in HOLD discards everything, with no error flags raised.
- in_ready = 1 in IDLE and COLLECT, 0 in HOLD (decoded from state).
- A byte is accepted on a rising edge when data_in_valid = 1 and in_ready = 1.
- Each accepted byte is shifted in as shift = {shift[119:0], data_in}, so the first byte ends up in bits [127:120].
- IDLE:
  - On an accepted byte: latch dest = key_sel, shift in the byte, count = 1, go to COLLECT.
- COLLECT:
  - Each accepted byte shifts in, increments count and clears the idle counter.
  - key_sel is ignored in this state.
  - A cycle without data_in_valid increments the idle counter.
  - When the idle counter reaches IDLE_TIMEOUT: pulse timeout_err, clear count and shift, return to IDLE. plaintext and key are left unchanged.
- 16th accepted byte, same edge, no added latency:
  - dest = 0: plaintext = {shift[119:0], data_in}, block_valid = 1, go to HOLD.
  - dest = 1: key = {shift[119:0], data_in}, key_valid = 1 for exactly one cycle, go to IDLE.
  - block_valid is not affected by a key load.
- HOLD:
  - block_valid stays at 1 and plaintext is stable.
  - The transfer occurs on the first rising edge with engine_ready = 1. On that edge block_valid = 0 and the state goes to IDLE, so in_ready = 1 from the next cycle.
  - engine_ready = 1 on the same edge as the 16th byte has no effect; the transfer needs a later edge.
- Output registers:
  - plaintext holds its value after transfer until the next plaintext block completes.
  - key holds until the next key load completes.
- Overflow:
  - data_in_valid = 1 while in_ready = 0 drops the byte and sets overflow_err. It stays 1 until reset.
  - This includes the HOLD cycle in which engine_ready completes the handshake: the byte is dropped and the error is set.
- Back-to-back streaming: 16 consecutive valid bytes complete a block in 16 cycles. Throughput is limited only by HOLD.
- Counter widths: count is 5 bits and never exceeds 16; the idle counter saturates and never wraps.

Test Plan:
- Plaintext load: after reset, stream bytes 0x00..0x0F on 16 consecutive edges with key_sel = 0 at byte 0, engine_ready = 0. Required: plaintext = 0x000102030405060708090A0B0C0D0E0F and block_valid = 1 right after the 16th edge; in_ready = 0. Raise engine_ready 3 cycles later: block_valid = 0 after that edge and in_ready = 1 next cycle.
- Key load: stream 0x2B7E151628AED2A6ABF7158809CF4F3C with key_sel = 1 at byte 0, and toggle key_sel during later bytes. Required: key equals that value, a single key_valid pulse, plaintext unchanged, state IDLE.
- Overflow: while in HOLD, drive data_in_valid = 1 with 0xAA. Required: overflow_err = 1 and stays 1, plaintext unchanged; overflow_err clears only on rst_ low.
- Timeout (IDLE_TIMEOUT = 4): send 5 bytes, then idle. Required: timeout_err pulses exactly on the 4th idle cycle and the state returns to IDLE. A following full 16-byte block assembles correctly with no residue from the first 5 bytes.
- Reset mid-block: assert rst_ low asynchronously (between clock edges) after 9 bytes. Required: all outputs 0 immediately. Then 16 new bytes produce the correct block.
- Gapped stream: 16 bytes with 1-3 idle cycles between bytes (below the timeout). Required: correct 128-bit block and no timeout_err.
